// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin, frame-locked sharing of one LCD character-write port between two requesters
//
// Ports:
//   CLK, RST                  clock; asynchronous active-low reset
//   rX_valid/rX_ready         requester X beat handshake (ready is combinational, IDLE only)
//   rX_row/rX_col/rX_char     requester X beat payload
//   rX_last                   requester X last beat of frame
//   lcd_row/lcd_col/lcd_char  registered payload to LCD driver, stable from ISSUE through WAIT
//   lcd_we                    one-cycle write strobe (ISSUE state)
//   lcd_busy                  LCD driver busy
//   grant                     one-hot owner of the open frame, 2'b00 when none
//   timeout_err               sticky flag: a write waited BUSY_TIMEOUT cycles on lcd_busy
module lcd_write_arbiter #(
  parameter int unsigned GUARD_CYC    = 2,
  parameter logic [31:0] BUSY_TIMEOUT = 32'd1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic       r0_row,
  input  logic [3:0] r0_col,
  input  logic [7:0] r0_char,
  input  logic       r0_last,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic       r1_row,
  input  logic [3:0] r1_col,
  input  logic [7:0] r1_char,
  input  logic       r1_last,
  output logic       lcd_row,
  output logic [3:0] lcd_col,
  output logic [7:0] lcd_char,
  output logic       lcd_we,
  input  logic       lcd_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  logic [1:0]  state_q, state_d;
  logic        row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [7:0]  char_q, char_d;
  logic [1:0]  grant_q, grant_d;
  logic        lock_q, lock_d;
  logic        prio_q, prio_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        elig0, elig1, pick1, accept, guard_ok;
  // While a frame is locked, grant_q names the owner and only it may be picked.
  assign elig0    = r0_valid & (~lock_q | grant_q[0]);
  assign elig1    = r1_valid & (~lock_q | grant_q[1]);
  assign pick1    = elig1 & (~elig0 | prio_q);
  assign accept   = (state_q == S_IDLE) & ~lcd_busy & (elig0 | elig1);
  assign guard_ok = cnt_q >= 32'(GUARD_CYC);
  assign r0_ready = accept & ~pick1;
  assign r1_ready = accept & pick1;
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    char_d  = char_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    if (state_q == S_IDLE) begin
      cnt_d = 32'd0;
      if (accept) begin
        state_d = S_ISSUE;
        row_d   = pick1 ? r1_row  : r0_row;
        col_d   = pick1 ? r1_col  : r0_col;
        char_d  = pick1 ? r1_char : r0_char;
        grant_d = pick1 ? 2'b10 : 2'b01;
        lock_d  = ~(pick1 ? r1_last : r0_last);
        prio_d  = (pick1 ? r1_last : r0_last) ? ~pick1 : prio_q;
      end
    end else if (state_q == S_ISSUE) begin
      state_d = S_WAIT;
      cnt_d   = 32'd1;
    end else if (guard_ok & ~lcd_busy) begin
      state_d = S_IDLE;
      cnt_d   = 32'd0;
      grant_d = lock_q ? grant_q : 2'b00;
    end else if (lcd_busy & (cnt_q >= BUSY_TIMEOUT)) begin
      // Abort the hung write: the beat is dropped and the frame is released.
      state_d = S_IDLE;
      cnt_d   = 32'd0;
      tmo_d   = 1'b1;
      lock_d  = 1'b0;
      grant_d = 2'b00;
    end else begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      row_q   <= 1'b0;
      col_q   <= 4'd0;
      char_q  <= 8'd0;
      grant_q <= 2'b00;
      lock_q  <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= 32'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      char_q  <= char_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
  assign lcd_we      = state_q == S_ISSUE;
  assign lcd_row     = row_q;
  assign lcd_col     = col_q;
  assign lcd_char    = char_q;
  assign grant       = grant_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed scoreboard bench for lcd_write_arbiter
module tb_lcd_write_arbiter;
  typedef struct packed {logic row; logic [3:0] col; logic [7:0] ch; logic last;} beat_t;
  typedef struct packed {logic row; logic [3:0] col; logic [7:0] ch; logic [1:0] g;} wr_t;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       r0_valid = 1'b0, r0_row = 1'b0, r0_last = 1'b0;
  logic [3:0] r0_col = 4'd0;
  logic [7:0] r0_char = 8'd0;
  logic       r1_valid = 1'b0, r1_row = 1'b0, r1_last = 1'b0;
  logic [3:0] r1_col = 4'd0;
  logic [7:0] r1_char = 8'd0;
  logic       lcd_busy = 1'b0;
  logic       r0_ready, r1_ready, lcd_row, lcd_we, timeout_err;
  logic [3:0] lcd_col;
  logic [7:0] lcd_char;
  logic [1:0] grant;
  beat_t src0[$], src1[$];
  wr_t   exp_q[$];
  int    n_chk = 0, n_fail = 0, we_cnt = 0, rdy0_cnt = 0;
  int    busy_len = 5;
  logic  busy_hold = 1'b0;
  logic [12:0] last_w = '0;
  lcd_write_arbiter #(.GUARD_CYC(2), .BUSY_TIMEOUT(32'd16)) dut (
    .CLK(CLK), .RST(RST),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_row(r0_row), .r0_col(r0_col), .r0_char(r0_char), .r0_last(r0_last),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_row(r1_row), .r1_col(r1_col), .r1_char(r1_char), .r1_last(r1_last),
    .lcd_row(lcd_row), .lcd_col(lcd_col), .lcd_char(lcd_char), .lcd_we(lcd_we), .lcd_busy(lcd_busy),
    .grant(grant), .timeout_err(timeout_err)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // requester sources and LCD busy responder: ready seen at negedge means the front beat is taken at the next edge
  always begin
    logic t0, t1, we;
    int   bcnt;
    @(negedge CLK);
    t0 = r0_ready;
    t1 = r1_ready;
    we = lcd_we;
    @(posedge CLK);
    #1;
    if (t0 && src0.size() > 0) void'(src0.pop_front());
    if (t1 && src1.size() > 0) void'(src1.pop_front());
    if (we) bcnt = busy_len;
    lcd_busy = busy_hold || bcnt > 0;
    if (bcnt > 0) bcnt--;
    r0_valid = src0.size() > 0;
    {r0_row, r0_col, r0_char, r0_last} = r0_valid ? src0[0] : '0;
    r1_valid = src1.size() > 0;
    {r1_row, r1_col, r1_char, r1_last} = r1_valid ? src1[0] : '0;
  end
  // write monitor: every strobe pops the scoreboard; payload must hold while a frame is open
  always @(negedge CLK) if (RST) begin
    wr_t e;
    chk("rdy_excl", 32'(r0_ready & r1_ready), 32'd0);
    chk("rdy0_needs_valid", 32'(r0_ready & ~r0_valid), 32'd0);
    chk("rdy1_needs_valid", 32'(r1_ready & ~r1_valid), 32'd0);
    if (r0_ready) rdy0_cnt++;
    if (lcd_we) begin
      we_cnt++;
      chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_data", 32'({lcd_row, lcd_col, lcd_char}), 32'({e.row, e.col, e.ch}));
        chk("wr_grant", 32'(grant), 32'(e.g));
      end
      last_w = {lcd_row, lcd_col, lcd_char};
    end else if (grant != 2'b00) begin
      chk("lcd_hold", 32'({lcd_row, lcd_col, lcd_char}), 32'(last_w));
    end
  end
  task automatic push(input int r, input logic row, input logic [3:0] col, input logic [7:0] ch, input logic last);
    if (r == 0) src0.push_back({row, col, ch, last});
    else src1.push_back({row, col, ch, last});
  endtask
  task automatic expect_wr(input logic row, input logic [3:0] col, input logic [7:0] ch, input logic [1:0] g);
    exp_q.push_back({row, col, ch, g});
  endtask
  task automatic wait_we(input int max);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!lcd_we && k < max);
    chk("we_seen", 32'(lcd_we), 32'd1);
  endtask
  task automatic wait_drain(input string tag, input int max);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0 || grant != 2'b00) && k < max);
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(grant), 32'd0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 32'(lcd_we), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    chk({tag, "_lcd"}, 32'({lcd_row, lcd_col, lcd_char}), 32'd0);
    chk({tag, "_rdy"}, 32'({r0_ready, r1_ready}), 32'd0);
  endtask
  initial begin
    int w0;
    // reset state
    repeat (2) @(negedge CLK);
    check_zero("reset");
    #2 RST = 1'b1;
    // 1: single r0 beat, busy pulses for 5 cycles after the strobe
    @(negedge CLK);
    push(0, 1'b0, 4'd3, 8'h41, 1'b1);
    expect_wr(1'b0, 4'd3, 8'h41, 2'b01);
    wait_we(20);
    chk("t1_char", 32'(lcd_char), 32'h41);
    chk("t1_col", 32'(lcd_col), 32'd3);
    repeat (6) @(negedge CLK);
    chk("t1_grant_wait", 32'(grant), 32'b01);
    @(negedge CLK);
    chk("t1_grant_idle", 32'(grant), 32'b00);
    chk("t1_we_cnt", 32'(we_cnt), 32'd1);
    chk("t1_rdy_cnt", 32'(rdy0_cnt), 32'd1);
    // 6: lcd_busy high in IDLE blocks acceptance until it falls
    busy_hold = 1'b1;
    repeat (2) @(negedge CLK);
    push(0, 1'b1, 4'd9, 8'h5a, 1'b1);
    expect_wr(1'b1, 4'd9, 8'h5a, 2'b01);
    w0 = we_cnt;
    repeat (8) begin
      @(negedge CLK);
      chk("t6_no_ready", 32'(r0_ready), 32'd0);
    end
    chk("t6_valid_held", 32'(r0_valid), 32'd1);
    chk("t6_no_we", 32'(we_cnt), 32'(w0));
    busy_hold = 1'b0;
    wait_drain("t6_drain", 60);
    chk("t6_rdy_cnt", 32'(rdy0_cnt), 32'd2);
    // 2: from reset both requesters stream 1-beat frames -> r0,r1,r0,r1
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    push(0, 1'b0, 4'd0, 8'h30, 1'b1);
    push(0, 1'b0, 4'd1, 8'h31, 1'b1);
    push(1, 1'b1, 4'd0, 8'h60, 1'b1);
    push(1, 1'b1, 4'd1, 8'h61, 1'b1);
    expect_wr(1'b0, 4'd0, 8'h30, 2'b01);
    expect_wr(1'b1, 4'd0, 8'h60, 2'b10);
    expect_wr(1'b0, 4'd1, 8'h31, 2'b01);
    expect_wr(1'b1, 4'd1, 8'h61, 2'b10);
    wait_drain("t2_drain", 200);
    // 3: r1 4-beat frame keeps the port although r0 (now prio) becomes valid mid-frame
    push(1, 1'b0, 4'd4, 8'h70, 1'b0);
    push(1, 1'b0, 4'd5, 8'h71, 1'b0);
    push(1, 1'b0, 4'd6, 8'h72, 1'b0);
    push(1, 1'b0, 4'd7, 8'h73, 1'b1);
    expect_wr(1'b0, 4'd4, 8'h70, 2'b10);
    expect_wr(1'b0, 4'd5, 8'h71, 2'b10);
    expect_wr(1'b0, 4'd6, 8'h72, 2'b10);
    expect_wr(1'b0, 4'd7, 8'h73, 2'b10);
    wait_we(20);
    push(0, 1'b1, 4'd15, 8'h7e, 1'b1);
    expect_wr(1'b1, 4'd15, 8'h7e, 2'b01);
    wait_drain("t3_drain", 200);
    // 4: busy stuck in WAIT -> timeout after 16 WAIT cycles, lock released
    push(0, 1'b0, 4'd2, 8'h21, 1'b0);
    expect_wr(1'b0, 4'd2, 8'h21, 2'b01);
    wait_we(20);
    busy_hold = 1'b1;
    repeat (16) @(negedge CLK);
    chk("t4_tmo_before", 32'(timeout_err), 32'd0);
    chk("t4_grant_before", 32'(grant), 32'b01);
    @(negedge CLK);
    chk("t4_tmo_set", 32'(timeout_err), 32'd1);
    chk("t4_grant_cleared", 32'(grant), 32'b00);
    busy_hold = 1'b0;
    push(1, 1'b1, 4'd8, 8'h42, 1'b1);
    expect_wr(1'b1, 4'd8, 8'h42, 2'b10);
    wait_drain("t4_drain", 60);
    chk("t4_tmo_sticky", 32'(timeout_err), 32'd1);
    // 5: reset in WAIT of a locked r1 frame; afterwards prio=r0 and lock clear
    push(1, 1'b0, 4'd10, 8'h55, 1'b0);
    expect_wr(1'b0, 4'd10, 8'h55, 2'b10);
    wait_we(20);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_zero("t5_rst");
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    push(0, 1'b0, 4'd11, 8'h50, 1'b1);
    push(1, 1'b1, 4'd12, 8'h51, 1'b1);
    expect_wr(1'b0, 4'd11, 8'h50, 2'b01);
    expect_wr(1'b1, 4'd12, 8'h51, 2'b10);
    wait_drain("t5_drain", 100);
    chk("t5_tmo_clear", 32'(timeout_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
